// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default widths for the MEM/WB access stage.
//   rf_d_sel_e : write-back source select encoding
//   state_e    : access controller states
package mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'd0,
        SEL_DM   = 2'd1,
        SEL_PC   = 2'd2,
        SEL_RSVD = 2'd3   // behaves like SEL_ALU
    } rf_d_sel_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating cycle counter that flags a memory access which
// has waited MAX_WAIT cycles without completing.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : force the count to zero (has priority over enable)
//   enable   : count one more waiting cycle
//   expire   : count has reached MAX_WAIT
module mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 8'd0;
        end else if (enable && (cnt_q != 8'(MAX_WAIT))) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == 8'(MAX_WAIT));

endmodule

// File: rtl/mem_wb_access.sv
// mem_wb_access: MEM stage. Issues a req/ack data-memory access for loads and
// stores, stalls upstream while the access is outstanding, and registers the
// selected write-back value as the MEM/WB outputs.
//   MEM_*      : EX/MEM pipeline register contents (held stable while stall=1)
//   dm_*       : data-memory port. dm_req rises with registered addr/wdata/we
//                and stays high, with those fields frozen, until the cycle in
//                which dm_ack=1 (or the wait timer aborts the access).
//   stall      : combinational hold request to EX/MEM and earlier stages
//   WB_*       : registered MEM/WB outputs, WB_VALID pulses once per retire
//   dm_err     : sticky flag, set when an access is aborted on timeout
module mem_wb_access
    import mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_VALID,
    input  logic              MEM_DM_WE,
    input  logic [DATA_W-1:0] MEM_ALU_RES,
    input  logic [DATA_W-1:0] MEM_muxB,
    input  logic [ADDR_W-1:0] MEM_DM_ADDR,
    input  logic [1:0]        MEM_RF_D_SEL,
    input  logic [DATA_W-1:0] MEM_NEXT_PC,
    input  logic [1:0]        MEM_RD_SEL,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              stall,
    output logic              WB_VALID,
    output logic              WB_RF_WE,
    output logic [DATA_W-1:0] WB_DATA,
    output logic [1:0]        WB_RD_SEL,
    output logic              dm_err
);

    state_e              state_q, state_d;
    logic                dm_req_q, dm_req_d;
    logic                dm_we_q, dm_we_d;
    logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;
    logic                wb_valid_q, wb_valid_d;
    logic                wb_rf_we_q, wb_rf_we_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [1:0]          wb_rd_sel_q, wb_rd_sel_d;
    logic                dm_err_q, dm_err_d;
    logic                stall_c;

    logic                need_mem;
    logic                is_load;
    logic [DATA_W-1:0]   sel_val;
    logic                timer_clear;
    logic                timer_enable;
    logic                timer_expire;

    // A store whose select says "memory" is still just a store.
    assign need_mem = MEM_VALID & (MEM_DM_WE | (MEM_RF_D_SEL == SEL_DM));
    assign is_load  = ~MEM_DM_WE & (MEM_RF_D_SEL == SEL_DM);
    assign sel_val  = (MEM_RF_D_SEL == SEL_PC) ? MEM_NEXT_PC : MEM_ALU_RES;

    // Counter value equals the number of ACCESS cycles already spent waiting.
    assign timer_clear  = (state_q == IDLE);
    assign timer_enable = (state_q == ACCESS) & ~dm_ack;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        dm_req_d    = dm_req_q;
        dm_we_d     = dm_we_q;
        dm_addr_d   = dm_addr_q;
        dm_wdata_d  = dm_wdata_q;
        wb_valid_d  = 1'b0;
        wb_rf_we_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_rd_sel_d = wb_rd_sel_q;
        dm_err_d    = dm_err_q;
        stall_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (need_mem) begin
                    // Detect cycle: launch the access, retire a bubble.
                    stall_c    = 1'b1;
                    state_d    = ACCESS;
                    dm_req_d   = 1'b1;
                    dm_we_d    = MEM_DM_WE;
                    dm_addr_d  = MEM_DM_ADDR;
                    dm_wdata_d = MEM_muxB;
                end else begin
                    wb_valid_d  = MEM_VALID;
                    wb_rf_we_d  = MEM_VALID & ~MEM_DM_WE;
                    wb_data_d   = sel_val;
                    wb_rd_sel_d = MEM_RD_SEL;
                end
            end
            ACCESS: begin
                // Ack takes priority over a simultaneous timeout.
                if (dm_ack) begin
                    state_d     = IDLE;
                    dm_req_d    = 1'b0;
                    wb_valid_d  = MEM_VALID;
                    wb_rf_we_d  = MEM_VALID & ~MEM_DM_WE;
                    wb_data_d   = is_load ? dm_rdata : sel_val;
                    wb_rd_sel_d = MEM_RD_SEL;
                end else if (timer_expire) begin
                    state_d  = IDLE;
                    dm_req_d = 1'b0;
                    dm_err_d = 1'b1;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_rf_we_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_sel_q <= 2'd0;
            dm_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_wdata_q  <= dm_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_rf_we_q  <= wb_rf_we_d;
            wb_data_q   <= wb_data_d;
            wb_rd_sel_q <= wb_rd_sel_d;
            dm_err_q    <= dm_err_d;
        end
    end

    // Stall is combinational; masking with rst keeps it low during reset
    // even if the upstream slot still presents a memory instruction.
    assign stall     = stall_c & ~rst;
    assign dm_req    = dm_req_q;
    assign dm_we     = dm_we_q;
    assign dm_addr   = dm_addr_q;
    assign dm_wdata  = dm_wdata_q;
    assign WB_VALID  = wb_valid_q;
    assign WB_RF_WE  = wb_rf_we_q;
    assign WB_DATA   = wb_data_q;
    assign WB_RD_SEL = wb_rd_sel_q;
    assign dm_err    = dm_err_q;

endmodule
